// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-number field type and pipeline controller state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline controller and the datapath it sequences.
// Latency: n/a (wiring only).
// Backpressure: n/a (wiring only).
//   master : controller side (hazard/hit inputs in, latch controls out)
//   slave  : datapath side (hazard/hit sources out, latch controls in)
interface pipeline_ctrl_if;
    import cpu_types_pkg::*;

    // hit lines and hazard sources
    logic     ihit;
    logic     dhit;
    logic     mem_req;
    logic     idex_MemRead;
    regbits_t idex_rt;
    regbits_t ifid_rs;
    regbits_t ifid_rt;
    logic     mispredict;
    logic     wb_halt;

    // latch controls
    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     exmem_flush;
    logic     idex_stall;
    logic     halt;

    modport master (
        input  ihit, dhit, mem_req, idex_MemRead, idex_rt, ifid_rs, ifid_rt,
               mispredict, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, idex_stall, halt
    );

    modport slave (
        output ihit, dhit, mem_req, idex_MemRead, idex_rt, ifid_rs, ifid_rt,
               mispredict, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, idex_stall, halt
    );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detect: ID/EX load whose destination feeds the IF/ID instruction.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides whether a hazard actually stalls.
//   idex_MemRead/idex_rt : load in ID/EX and its destination
//   ifid_rs/ifid_rt      : sources of the instruction in IF/ID
//   lu                   : hazard present
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_MemRead,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     lu
);

    // $zero is never a real dependency
    assign lu = idex_MemRead && (idex_rt != '0) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: PC/latch enables, flushes, ID/EX bubble and sticky halt.
// Latency: Mealy outputs, decisions take effect on the next CLK edge (0 added cycles).
// Backpressure: freezes the whole pipe while a data access is outstanding (MEMWAIT).
//   CLK/nRST : clock, async active-low reset
//   ctrl     : pipeline_ctrl_if master (hit/hazard inputs, latch controls)
//   stall_count/flush_count : present only when PIPE_CTRL_STATS_EN is defined
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_ctrl_if.master      ctrl
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [31:0]          stall_count,
    output logic [31:0]          flush_count
`endif
);

    pipe_ctrl_state_t state, state_next;

    logic lu;
    logic advance;
    logic data_done;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, idex_stall, halt;

    load_use_detect u_lu (
        .idex_MemRead (ctrl.idex_MemRead),
        .idex_rt      (ctrl.idex_rt),
        .ifid_rs      (ctrl.ifid_rs),
        .ifid_rt      (ctrl.ifid_rt),
        .lu           (lu)
    );

    // fetch only counts when the data side is not using memory
    assign advance = ctrl.ihit && !ctrl.mem_req;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        data_done   = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        idex_stall  = 1'b0;
        halt        = 1'b0;

        case (state)
            RUN: begin
                if (ctrl.wb_halt) begin
                    state_next = HALTED;
                end else if (ctrl.mem_req && !ctrl.dhit) begin
                    state_next = MEMWAIT;
                end else if (ctrl.mem_req) begin
                    data_done = 1'b1;
                end else if (advance && ctrl.mispredict) begin
                    // wrong-path instructions in IF/ID, ID/EX, EX/MEM are squashed;
                    // any load-use against them is moot
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (advance && lu) begin
                    idex_en    = 1'b1;
                    idex_stall = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (advance) begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            end
            MEMWAIT: begin
                // MEM/WB is frozen here, so wb_halt cannot appear
                if (ctrl.dhit) begin
                    data_done  = 1'b1;
                    state_next = RUN;
                end
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        // Data completion: back half drains, front half holds and a bubble
        // enters ID/EX. A branch resolved in EX/MEM redirects the PC now.
        if (data_done) begin
            idex_en    = 1'b1;
            idex_stall = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (ctrl.mispredict) begin
                pc_en       = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
        end
    end

    assign ctrl.pc_en       = pc_en;
    assign ctrl.ifid_en     = ifid_en;
    assign ctrl.idex_en     = idex_en;
    assign ctrl.exmem_en    = exmem_en;
    assign ctrl.memwb_en    = memwb_en;
    assign ctrl.ifid_flush  = ifid_flush;
    assign ctrl.idex_flush  = idex_flush;
    assign ctrl.exmem_flush = exmem_flush;
    assign ctrl.idex_stall  = idex_stall;
    assign ctrl.halt        = halt;

`ifdef PIPE_CTRL_STATS_EN
    // both counters freeze once halted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (state != HALTED) begin
            if (!pc_en) begin
                stall_count <= stall_count + 32'd1;
            end
            if (ifid_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized run
// against a priority-table reference model.
// Output vector order: pc,ifid,idex,exmem,memwb en | ifid,idex,exmem flush | stall | halt
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;

    pipeline_ctrl_if pif ();

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    pipeline_ctrl dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ctrl (pif)
`ifdef PIPE_CTRL_STATS_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests;
    int n_fail;

    // model: 0 running, 1 waiting on data, 2 halted
    int          m_state;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    localparam logic [9:0] V_IDLE   = 10'b0000000000;
    localparam logic [9:0] V_GO     = 10'b1111100000;
    localparam logic [9:0] V_BUBBLE = 10'b0011100010;
    localparam logic [9:0] V_FLUSH  = 10'b1111111100;
    localparam logic [9:0] V_DMISP  = 10'b1011111110;
    localparam logic [9:0] V_HALT   = 10'b0000000001;

    function automatic logic [9:0] obs_vec();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.idex_stall, pif.halt};
    endfunction

    function automatic logic [9:0] model_out(int st);
        bit hazard;
        bit adv;
        hazard = pif.idex_MemRead && (pif.idex_rt != 5'd0) &&
                 (pif.idex_rt == pif.ifid_rs || pif.idex_rt == pif.ifid_rt);
        adv = pif.ihit && !pif.mem_req;
        if (st == 2) return V_HALT;
        if (st == 1) return pif.dhit ? (pif.mispredict ? V_DMISP : V_BUBBLE) : V_IDLE;
        if (pif.wb_halt) return V_IDLE;
        if (pif.mem_req) return !pif.dhit ? V_IDLE : (pif.mispredict ? V_DMISP : V_BUBBLE);
        if (adv && pif.mispredict) return V_FLUSH;
        if (adv && hazard) return V_BUBBLE;
        if (adv) return V_GO;
        return V_IDLE;
    endfunction

    function automatic int model_next(int st);
        if (st == 2) return 2;
        if (st == 1) return pif.dhit ? 0 : 1;
        if (pif.wb_halt) return 2;
        if (pif.mem_req && !pif.dhit) return 1;
        return 0;
    endfunction

    task automatic set_in(input bit ih, input bit dh, input bit mr, input bit ld,
                          input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2,
                          input bit mp, input bit wh);
        pif.ihit = ih; pif.dhit = dh; pif.mem_req = mr; pif.idex_MemRead = ld;
        pif.idex_rt = rt; pif.ifid_rs = rs; pif.ifid_rt = rt2;
        pif.mispredict = mp; pif.wb_halt = wh;
    endtask

    // called after the negedge sample: advance the model across the next edge
    task automatic finish_cycle();
        logic [9:0] e;
        int nxt;
        e = model_out(m_state);
        nxt = model_next(m_state);
        if (m_state != 2) begin
            if (!e[9]) m_stall = m_stall + 32'd1;
            if (e[4]) m_flush = m_flush + 32'd1;
        end
        @(posedge CLK);
        m_state = nxt;
        #1;
    endtask

    task automatic apply_reset(input string name);
        logic [9:0] e;
        nRST = 1'b0;
        m_state = 0;
        m_stall = '0;
        m_flush = '0;
        #2;
        e = model_out(0);
        n_tests++;
        if (obs_vec() !== e || dut.state !== RUN) begin
            n_fail++;
            $display("FAIL %s: outs=%b state=%0d required outs=%b state=RUN", name, obs_vec(), dut.state, e);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_reset("reset_outputs");
        n_tests++;
        if (pif.halt !== 1'b0 || obs_vec() !== V_GO) begin
            n_fail++;
            $display("FAIL reset_const: outs=%b required %b", obs_vec(), V_GO);
        end
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 1, 5, 5, 7, 0, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_BUBBLE) begin
            n_fail++;
            $display("FAIL load_use: outs=%b required %b", obs_vec(), V_BUBBLE);
        end
        finish_cycle();
        // bubble now in ID/EX; dependency gone
        set_in(1, 0, 0, 0, 0, 5, 7, 0, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_GO) begin
            n_fail++;
            $display("FAIL load_use_release: outs=%b required %b", obs_vec(), V_GO);
        end
        finish_cycle();
        set_in(1, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_GO) begin
            n_fail++;
            $display("FAIL load_use_r0: outs=%b required %b", obs_vec(), V_GO);
        end
        finish_cycle();
        set_in(1, 0, 0, 1, 9, 3, 9, 0, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_BUBBLE) begin
            n_fail++;
            $display("FAIL load_use_rt: outs=%b required %b", obs_vec(), V_BUBBLE);
        end
        finish_cycle();
    endtask

    task automatic test_memwait();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
            @(negedge CLK);
            n_tests++;
            if (obs_vec() !== V_IDLE) begin
                n_fail++;
                $display("FAIL memwait_freeze%0d: outs=%b required %b", i, obs_vec(), V_IDLE);
            end
            finish_cycle();
            n_tests++;
            if (dut.state !== MEMWAIT) begin
                n_fail++;
                $display("FAIL memwait_state%0d: state=%0d required MEMWAIT", i, dut.state);
            end
        end
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_BUBBLE) begin
            n_fail++;
            $display("FAIL memwait_done: outs=%b required %b", obs_vec(), V_BUBBLE);
        end
        finish_cycle();
        n_tests++;
        if (dut.state !== RUN) begin
            n_fail++;
            $display("FAIL memwait_return: state=%0d required RUN", dut.state);
        end
        // dhit without mem_req is ignored
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_GO) begin
            n_fail++;
            $display("FAIL stray_dhit: outs=%b required %b", obs_vec(), V_GO);
        end
        finish_cycle();
    endtask

    task automatic test_mispredict();
        set_in(1, 0, 0, 1, 5, 5, 5, 1, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_FLUSH) begin
            n_fail++;
            $display("FAIL mispredict_over_lu: outs=%b required %b", obs_vec(), V_FLUSH);
        end
        finish_cycle();
        // mispredict held through a freeze is taken when data completes
        set_in(0, 1, 1, 0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_DMISP) begin
            n_fail++;
            $display("FAIL mispredict_dhit: outs=%b required %b", obs_vec(), V_DMISP);
        end
        finish_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_IDLE) begin
            n_fail++;
            $display("FAIL mispredict_no_ihit: outs=%b required %b", obs_vec(), V_IDLE);
        end
        finish_cycle();
    endtask

    task automatic test_halt();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        n_tests++;
        if (obs_vec() !== V_IDLE) begin
            n_fail++;
            $display("FAIL halt_entry: outs=%b required %b", obs_vec(), V_IDLE);
        end
        finish_cycle();
        for (int i = 0; i < 10; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            @(negedge CLK);
            n_tests++;
            if (obs_vec() !== V_HALT) begin
                n_fail++;
                $display("FAIL halt_sticky%0d: outs=%b required %b", i, obs_vec(), V_HALT);
            end
            finish_cycle();
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_reset("halt_reset");
    endtask

    task automatic test_random();
        int halted_cycles;
        logic [9:0] e;
        halted_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) < 3,
                   1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
                   (m_state == 0) && ($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 99) == 0 || halted_cycles > 3) begin
                halted_cycles = 0;
                apply_reset("random_reset");
            end else begin
                @(negedge CLK);
                e = model_out(m_state);
                n_tests++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL random_cycle%0d: outs=%b required %b (model state %0d)",
                             i, obs_vec(), e, m_state);
                end
                finish_cycle();
                halted_cycles = (m_state == 2) ? halted_cycles + 1 : 0;
            end
        end
`ifdef PIPE_CTRL_STATS_EN
        n_tests++;
        if (stall_count !== m_stall || flush_count !== m_flush) begin
            n_fail++;
            $display("FAIL random_stats: stall=%0d flush=%0d required stall=%0d flush=%0d",
                     stall_count, flush_count, m_stall, m_flush);
        end
`endif
    endtask

`ifdef PIPE_CTRL_STATS_EN
    task automatic test_stats();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_reset("stats_reset");
        n_tests++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_zero: stall=%0d flush=%0d required 0 0", stall_count, flush_count);
        end
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 2:    set_in(1, 0, 0, 1, 5, 5, 0, 0, 0);
                4:       set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
                default: set_in(1, 0, 0, 0, 0, 1, 2, 0, 0);
            endcase
            @(negedge CLK);
            finish_cycle();
        end
        n_tests++;
        if (stall_count !== 32'd2 || flush_count !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_count: stall=%0d flush=%0d required 2 1", stall_count, flush_count);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_state = 0;
        m_stall = '0;
        m_flush = '0;
        nRST    = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        test_reset();
        test_load_use();
        test_memwait();
        test_mispredict();
        test_halt();
`ifdef PIPE_CTRL_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It arbitrates between instruction-fetch and data-memory completion (`ihit`/`dhit`), load-use hazards, branch/jump mispredict recovery, and halt. It drives the enable, flush and stall (bubble) inputs of every pipeline register and the PC write enable. It sits beside the datapath and is fed by decode fields, EX-stage control bits, and the memory controller's hit lines.

## Interface
Parameters:
- none

Ports:
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: instruction fetch complete this cycle.
- `dhit` in 1: data access complete this cycle.
- `mem_req` in 1: EX/MEM instruction has `MemRead` or `MemWr` set.
- `idex_MemRead` in 1: ID/EX instruction is a load.
- `idex_rt` in 5: load destination register in ID/EX.
- `ifid_rs`, `ifid_rt` in 5 each: source registers of the instruction in IF/ID.
- `mispredict` in 1: EX/MEM branch/jump resolved against the fetched path.
- `wb_halt` in 1: `halt` bit of the MEM/WB stage.
- `pc_en` out 1: PC write enable.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: latch enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1 each: zero the latch on the next edge.
- `idex_stall` out 1: load a bubble into ID/EX; only meaningful with `idex_en`.
- `halt` out 1: CPU halted, sticky.

## Operation
States: `RUN`, `MEMWAIT`, `HALTED`. Outputs are Mealy, driven from the state and the current inputs. Default for all enables, flushes, stall and `halt` is 0.

Signal definitions:
- `lu` = `idex_MemRead` & (`idex_rt`≠0) & (`idex_rt`==`ifid_rs` | `idex_rt`==`ifid_rt`).
- `advance` = `ihit` & ~`mem_req`.

Priority in `RUN` (first match wins):
1. `wb_halt`: all enables 0. Next state is `HALTED`.
2. `mem_req` & ~`dhit`: freeze (all enables 0). Next state is `MEMWAIT`.
3. `mem_req` & `dhit` (data completion cycle):
   - `pc_en`=`ifid_en`=0.
   - `idex_en`=1, `idex_stall`=1.
   - `exmem_en`=`memwb_en`=1.
   - If `mispredict`: also assert `pc_en`, `ifid_flush`, `idex_flush`, `exmem_flush`.
4. `advance` & `mispredict`:
   - All enables 1.
   - `ifid_flush`=`idex_flush`=`exmem_flush`=1.
   - Load-use is ignored.
5. `advance` & `lu`:
   - `pc_en`=`ifid_en`=0.
   - `idex_en`=1, `idex_stall`=1.
   - `exmem_en`=`memwb_en`=1.
6. `advance`: all enables 1.
7. Otherwise (~`ihit`, no `mem_req`): all enables 0.

`MEMWAIT`:
- All enables 0 until `dhit`.
- On `dhit`, apply rule 3 and return to `RUN`.
- `wb_halt` is never true here, because MEM/WB is frozen.

`HALTED`:
- `halt`=1; all enables and flushes 0.
- Absorbing; only `nRST` exits.

Boundaries:
- `dhit` without `mem_req` is ignored.
- `ihit` together with `mem_req` is ignored, because the data path owns memory.
- `idex_rt`=0 never stalls.
- A mispredict during a freeze is held by the frozen EX/MEM latch and taken on the first advancing cycle.

## Timing
- Reset (async, during `~nRST`):
  - State is `RUN`; `halt`=0.
  - Stats counters (if configured) are 0.
  - Outputs follow the combinational rules for the current inputs.
- All decisions take effect on the next `CLK` edge; there are zero cycles of added latency.
- A load-use hazard costs exactly 1 bubble cycle.
- A mispredict costs 3 flushed slots.
- `halt` rises one cycle after the edge at which `wb_halt` is sampled in `RUN`.
- Reset asserted mid-`MEMWAIT` or mid-`HALTED` returns to `RUN` immediately.

## Configuration
- Macro: `PIPE_CTRL_STATS_EN`.
- Defined:
  - Adds outputs `stall_count` (32) and `flush_count` (32).
  - `stall_count` increments on every cycle in which `pc_en`=0 and state≠`HALTED`.
  - `flush_count` increments on every cycle with `ifid_flush`=1.
  - Both counters wrap modulo 2^32 and freeze in `HALTED`.
- Undefined: the ports and counters are absent.

## Structure
- `cpu_types_pkg` gets enum `pipe_ctrl_state_t` {`RUN`, `MEMWAIT`, `HALTED`}.
- Register-number fields use the existing `regbits_t`.
- Sub-module `load_use_detect` is purely combinational: it computes `lu` from `idex_MemRead`, `idex_rt`, `ifid_rs` and `ifid_rt`.
- The FSM and output logic live in `pipeline_ctrl`.

## Test plan
- Reset with `ihit`=1 and no other requests → `halt`=0, all enables 1, no flush.
- Load-use: `idex_MemRead`=1, `idex_rt`=5, `ifid_rs`=5, `ihit`=1 → `pc_en`=0, `idex_stall`=1 for 1 cycle. Repeat with `idex_rt`=0 → no stall.
- Data wait: `mem_req`=1 with `dhit` low for 3 cycles → state `MEMWAIT` and all enables 0. Then `dhit`=1 → `idex_stall`=1, `exmem_en`=1, `pc_en`=0, state `RUN`.
- `mispredict`=1 with `ihit`=1 and `lu` also true → all 3 flushes set, `pc_en`=1, `idex_stall`=0.
- `wb_halt`=1 → next cycle `halt`=1. `halt` stays 1 for 10 cycles regardless of inputs. Then `nRST` pulse → `halt`=0.
- With `PIPE_CTRL_STATS_EN`: 2 load-use stalls plus 1 mispredict → `stall_count`=2, `flush_count`=1.
